relu_frame_tx: RTL and testbench



---
 rtl/relu_tx_pkg.sv | 29 ++
 rtl/relu_frame_tx_if.sv | 11 +
 rtl/relu_bit_timer.sv | 39 +++
 rtl/relu_frame_tx.sv | 178 +++++++++++++++++
 tb/tb_relu_frame_tx.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/relu_tx_pkg.sv
// Shared state type, default sizing and ReLU helper for the ReLU frame transmitter.
package relu_tx_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } tx_state_e;

   localparam int unsigned DEF_WIDTH   = 8;
   localparam int unsigned DEF_DEPTH   = 4;
   localparam int unsigned DEF_CLK_DIV = 4;

   localparam int unsigned BIT_CNT_W = $clog2(DEF_DEPTH * DEF_WIDTH);
   localparam int unsigned DIV_CNT_W = $clog2(DEF_CLK_DIV);

   function automatic int unsigned bit_cnt_w(input int unsigned depth, input int unsigned width);
      return $clog2(depth * width);
   endfunction

   function automatic int unsigned div_cnt_w(input int unsigned clk_div);
      return $clog2(clk_div);
   endfunction

   function automatic logic [7:0] relu8(input logic signed [7:0] x);
      return x[7] ? 8'h00 : $unsigned(x);
   endfunction

endpackage

// File: rtl/relu_frame_tx_if.sv
// Sample stream handshake into the ReLU frame transmitter.
interface relu_frame_tx_if #(
   parameter int unsigned WIDTH = relu_tx_pkg::DEF_WIDTH
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/relu_bit_timer.sv
// Serial bit-period divider: tracks the phase within a CLK_DIV-clock bit and flags its last clock.
module relu_bit_timer
   import relu_tx_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic bit_end,
   output logic sclk_next
);

   localparam int unsigned DIV_W = div_cnt_w(CLK_DIV);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;

   // sclk_next is the phase of the following clock, so the caller can register it.
   always_comb begin
      bit_end = run && (div_q == DIV_W'(CLK_DIV - 1));
      if (clr || !run || bit_end) begin
         div_d = '0;
      end else begin
         div_d = div_q + DIV_W'(1);
      end
      sclk_next = (div_d >= DIV_W'(CLK_DIV / 2));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/relu_frame_tx.sv
// ReLU tile back end: captures rectified samples into a DEPTH-word frame and shifts it out MSB-first.
module relu_frame_tx
   import relu_tx_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned DEPTH   = DEF_DEPTH,
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   relu_frame_tx_if.slave        in_if,
   output logic                  tx_cs_n,
   output logic                  tx_sclk,
   output logic                  tx_sdo,
   output logic                  busy,
   output logic [7:0]            frame_cnt
);

   localparam int unsigned TOTAL = DEPTH * WIDTH;
   localparam int unsigned BIT_W = bit_cnt_w(DEPTH, WIDTH);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   tx_state_e        state_q, state_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
   logic             cs_n_q, cs_n_d;
   logic             sclk_q, sclk_d;
   logic             sdo_q, sdo_d;
   logic             busy_q, busy_d;
   logic             in_ready_q, in_ready_d;
   logic [7:0]       frame_cnt_q, frame_cnt_d;

   logic             wr_en;
   logic             last_word;
   logic             timer_clr;
   logic             timer_run;
   logic             bit_end;
   logic             sclk_next;
   logic [WIDTH-1:0] relu_w;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [TOTAL-1:0] frame_bits;

   if (WIDTH == 8) begin : g_relu8
      assign relu_w = relu8(in_if.in_data);
   end else begin : g_relu_n
      assign relu_w = in_if.in_data[WIDTH-1] ? '0 : in_if.in_data;
   end

   // Word 0 sits in the top bits so stream index i maps to frame_bits[TOTAL-1-i].
   always_comb begin
      frame_bits = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         frame_bits[(DEPTH - 1 - i) * WIDTH +: WIDTH] = mem_q[i];
      end
   end

   assign last_word = (wptr_q == PTR_W'(DEPTH - 1));
   assign timer_run = ena && (state_q != FILL);
   assign timer_clr = !ena || (wr_en && last_word);

   relu_bit_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (timer_clr),
      .run       (timer_run),
      .bit_end   (bit_end),
      .sclk_next (sclk_next)
   );

   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      bit_idx_d   = bit_idx_q;
      cs_n_d      = 1'b1;
      sclk_d      = 1'b0;
      sdo_d       = 1'b0;
      busy_d      = 1'b0;
      in_ready_d  = 1'b0;
      frame_cnt_d = frame_cnt_q;
      wr_en       = 1'b0;

      if (!ena) begin
         state_d   = FILL;
         wptr_d    = '0;
         bit_idx_d = '0;
      end else begin
         case (state_q)
            FILL: begin
               in_ready_d = 1'b1;
               if (in_if.in_valid && in_ready_q) begin
                  wr_en  = 1'b1;
                  wptr_d = wptr_q + PTR_W'(1);
                  if (last_word) begin
                     state_d    = SHIFT;
                     wptr_d     = '0;
                     bit_idx_d  = '0;
                     in_ready_d = 1'b0;
                     cs_n_d     = 1'b0;
                     busy_d     = 1'b1;
                     sdo_d      = frame_bits[TOTAL-1];
                  end
               end
            end
            SHIFT: begin
               cs_n_d = 1'b0;
               busy_d = 1'b1;
               sclk_d = sclk_next;
               sdo_d  = sdo_q;
               if (bit_end) begin
                  if (bit_idx_q == BIT_W'(TOTAL - 1)) begin
                     state_d     = GAP;
                     cs_n_d      = 1'b1;
                     sclk_d      = 1'b0;
                     sdo_d       = 1'b0;
                     frame_cnt_d = frame_cnt_q + 8'd1;
                  end else begin
                     bit_idx_d = bit_idx_q + BIT_W'(1);
                     sdo_d     = frame_bits[BIT_W'(TOTAL - 1) - bit_idx_d];
                  end
               end
            end
            GAP: begin
               busy_d = 1'b1;
               if (bit_end) begin
                  state_d    = FILL;
                  busy_d     = 1'b0;
                  in_ready_d = 1'b1;
               end
            end
            default: begin
               state_d = FILL;
               wptr_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         wptr_q      <= '0;
         bit_idx_q   <= '0;
         cs_n_q      <= 1'b1;
         sclk_q      <= 1'b0;
         sdo_q       <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         bit_idx_q   <= bit_idx_d;
         cs_n_q      <= cs_n_d;
         sclk_q      <= sclk_d;
         sdo_q       <= sdo_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wptr_q] <= relu_w;
      end
   end

   assign in_if.in_ready = in_ready_q;
   assign tx_cs_n        = cs_n_q;
   assign tx_sclk        = sclk_q;
   assign tx_sdo         = sdo_q;
   assign busy           = busy_q;
   assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_relu_frame_tx.sv
// Scoreboard bench for relu_frame_tx: accepted samples feed an expected-word queue, a serial decoder pops and compares.
module tb_relu_frame_tx;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned FRAME_CLKS = DEPTH * WIDTH * CLK_DIV;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       tx_cs_n, tx_sclk, tx_sdo, busy;
   logic [7:0] frame_cnt;

   relu_frame_tx_if #(.WIDTH(WIDTH)) in_if ();

   relu_frame_tx #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .in_if     (in_if),
      .tx_cs_n   (tx_cs_n),
      .tx_sclk   (tx_sclk),
      .tx_sdo    (tx_sdo),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;

   logic [7:0] stim_q [$];
   logic [7:0] acc_q [$];
   logic [7:0] exp_q [$];
   bit         bubbles = 0;
   int         cyc = 0;
   int         last_acc_cyc = -100;

   // monitor state shared with the main sequence
   int  fbits = 0;
   int  mon_frames = 0;
   int  exp_fc = 0;
   int  last_fc = 0;
   bit  abort_pending = 0;
   bit  reset_pending = 0;
   bit  wrap_seen = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   function automatic logic [7:0] relu_ref(input logic [7:0] d);
      return ($signed(d) < 0) ? 8'd0 : d;
   endfunction

   always @(posedge clk) cyc++;

   // Driver: holds a sample until the handshake completes; expectations are pushed on acceptance.
   initial begin
      bit hs;
      in_if.in_valid = 1'b0;
      in_if.in_data  = '0;
      forever begin
         @(negedge clk);
         hs = in_if.in_valid && in_if.in_ready && ena && rst_n;
         @(posedge clk);
         #1;
         if (hs) begin
            acc_q.push_back(relu_ref(in_if.in_data));
            last_acc_cyc = cyc;
            if (acc_q.size() == DEPTH) begin
               foreach (acc_q[k]) exp_q.push_back(acc_q[k]);
               acc_q.delete();
            end
            in_if.in_valid = 1'b0;
         end
         if (!in_if.in_valid && stim_q.size() > 0 && !(bubbles && $urandom_range(3) == 0)) begin
            in_if.in_data  = stim_q.pop_front();
            in_if.in_valid = 1'b1;
         end
      end
   end

   // Monitor: decodes the serial link on sclk rising edges, sampled mid-cycle.
   initial begin
      bit         prev_cs = 1'b1;
      bit         prev_sclk = 1'b0;
      int         low_cnt = 0;
      int         wbits = 0;
      int         mon_word = 0;
      int         gap_cnt = 0;
      bit         gap_track = 0;
      logic [7:0] word = '0;
      logic [7:0] ew;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (tx_cs_n) chk("idle_lines_low", {30'd0, tx_sclk, tx_sdo}, 0);
            if (busy) chk("no_ready_while_busy", int'(in_if.in_ready), 0);

            if (gap_track) begin
               if (in_if.in_ready) begin
                  chk("gap_len_to_ready", gap_cnt, CLK_DIV);
                  gap_track = 0;
               end else begin
                  gap_cnt++;
               end
            end

            if (!tx_cs_n) begin
               if (prev_cs) begin
                  low_cnt = 0; fbits = 0; wbits = 0; mon_word = 0;
                  chk("cs_low_one_clk_after_last_accept", cyc, last_acc_cyc);
               end
               low_cnt++;
               if (!prev_sclk && tx_sclk) begin
                  word = {word[6:0], tx_sdo};
                  fbits++;
                  wbits++;
                  if (wbits == WIDTH) begin
                     wbits = 0;
                     if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL word_unexpected: got 0x%0h with empty scoreboard at %0t", word, $time);
                     end else begin
                        ew = exp_q.pop_front();
                        chk("serial_word", word, ew);
                     end
                     mon_word++;
                  end
               end
            end

            if (tx_cs_n && !prev_cs) begin
               if (abort_pending || reset_pending) begin
                  for (int k = mon_word; k < DEPTH; k++) if (exp_q.size() > 0) void'(exp_q.pop_front());
                  chk("aborted_frame_cnt", frame_cnt, exp_fc);
                  chk("aborted_busy", busy, 0);
                  chk("aborted_sclk", tx_sclk, 0);
                  if (reset_pending) last_fc = 0;
                  abort_pending = 0;
                  reset_pending = 0;
               end else begin
                  exp_fc = (exp_fc + 1) % 256;
                  chk("cs_low_clks", low_cnt, FRAME_CLKS);
                  chk("frame_bits", fbits, DEPTH * WIDTH);
                  chk("frame_cnt", frame_cnt, exp_fc);
                  if (last_fc == 255 && frame_cnt == 8'd0) wrap_seen = 1;
                  last_fc = frame_cnt;
                  gap_track = 1;
                  gap_cnt = 1;
                  mon_frames++;
               end
               wbits = 0;
               mon_word = 0;
            end
         end
         prev_cs = tx_cs_n;
         prev_sclk = tx_sclk;
      end
   end

   task automatic push4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
      stim_q.push_back(a); stim_q.push_back(b); stim_q.push_back(c); stim_q.push_back(d);
   endtask

   task automatic wait_frames(input int target, input int budget);
      int n = 0;
      while (mon_frames < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("frames_done", mon_frames, target);
   endtask

   task automatic wait_shift_bits(input int nbits);
      int n = 0;
      while (!(!tx_cs_n && fbits >= nbits && fbits < DEPTH * WIDTH) && n < 2000) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("shift_point_reached", int'(fbits >= nbits), 1);
   endtask

   initial begin
      int base;
      rst_n = 1'b0;
      ena   = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_cs_n", tx_cs_n, 1);
      chk("rst_sclk", tx_sclk, 0);
      chk("rst_sdo", tx_sdo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_if.in_ready, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      ena = 1'b1;

      // basic frame, ReLU boundaries, backpressure with a held fifth sample
      push4(8'h12, 8'h85, 8'h7F, 8'h00);
      wait_frames(1, 400);
      push4(8'h80, 8'hFF, 8'h01, 8'h7F);
      wait_frames(2, 400);
      push4(8'hA5, 8'h3C, 8'hC3, 8'h5A);
      stim_q.push_back(8'h33);
      wait_frames(3, 400);
      stim_q.push_back(8'h44); stim_q.push_back(8'h9E); stim_q.push_back(8'h21);
      wait_frames(4, 400);

      // abort around bit 10, then a clean frame
      push4(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      wait_shift_bits(10);
      abort_pending = 1;
      ena = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      ena = 1'b1;
      push4(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      wait_frames(5, 400);

      // asynchronous reset in the middle of a frame
      push4(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      wait_shift_bits(5);
      @(posedge clk);
      #2;
      reset_pending = 1;
      exp_fc = 0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_cs_n", tx_cs_n, 1);
      chk("async_rst_sclk", tx_sclk, 0);
      chk("async_rst_sdo", tx_sdo, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_in_ready", in_if.in_ready, 0);
      chk("async_rst_frame_cnt", frame_cnt, 0);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_fill_ready", in_if.in_ready, 1);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_frame_cnt", frame_cnt, 0);

      // 256 random frames with input bubbles: frame_cnt wraps 255 -> 0
      bubbles = 1;
      base = mon_frames;
      for (int f = 0; f < 256; f++) begin
         push4(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      wait_frames(base + 256, 256 * 220);
      repeat (10) @(posedge clk);
      #2;
      chk("final_frame_cnt", frame_cnt, 0);
      chk("wrap_255_to_0_seen", wrap_seen, 1);
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("no_partial_frame", acc_q.size(), 0);
      chk("stimulus_drained", stim_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
